// File: rtl/nanov_digit_alu.sv
// nanov_digit_alu: digit-serial RV32 OP/OP-IMM execution unit.
// Operands arrive DIGIT_W bits per cycle, LSB digit first, from a digit-addressed
// register file. Each result digit is written back in the same cycle its index is presented.
// Single-pass ops (ADD/SUB/logic) emit rd directly. Two-pass ops (shifts, SLT/SLTU)
// first run a capture pass over the operands, then emit rd in a second pass.
module nanov_digit_alu #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4,
  localparam int NDIG   = XLEN / DIGIT_W,
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic               use_imm,
  input  logic [XLEN-1:0]    imm,
  input  logic [DIGIT_W-1:0] rs1_digit,
  input  logic [DIGIT_W-1:0] rs2_digit,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [DIGIT_W-1:0] rd_digit,
  output logic               rd_wr,
  output logic               busy,
  output logic               done,
  output logic [2:0]         flags
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  state_t              state_r;
  logic [2:0]          f3_r;
  logic                alt_r;      // SUB for funct3=000, SRA for funct3=101
  logic                use_imm_r;
  logic                carry_r;
  logic                eq_r;
  logic [XLEN-1:0]     buf_r;
  logic [4:0]          shamt_r;
  logic [IDX_W-1:0]    idx_r;
  logic                rd_wr_r;
  logic                busy_r;
  logic                done_r;
  logic [2:0]          flags_r;

  logic                last_s;
  logic [DIGIT_W-1:0]  b_s;
  logic                inv_s;
  logic [DIGIT_W-1:0]  b_eff_s;
  logic [DIGIT_W:0]    sum_s;
  logic                eq_nxt_s;
  logic                lt_s;
  logic                ltu_s;
  logic [4:0]          shamt_cap_s;
  logic [4:0]          shamt_use_s;
  logic [XLEN-1:0]     shifted_s;
  logic [DIGIT_W-1:0]  shift_dig_s;
  logic [2:0]          acc_f3_s;
  logic                acc_sub_s;
  logic                acc_two_pass_s;

  // Accept-time decode of the incoming op; op[3] only selects SUB for register-register ADD.
  always_comb begin
    acc_f3_s       = op[2:0];
    acc_sub_s      = 1'b0;
    acc_two_pass_s = 1'b0;
    case (op[2:0])
      3'b000:  acc_sub_s      = op[3] & ~use_imm;
      3'b001:  acc_two_pass_s = 1'b1;
      3'b010:  begin acc_two_pass_s = 1'b1; acc_sub_s = 1'b1; end
      3'b011:  begin acc_two_pass_s = 1'b1; acc_sub_s = 1'b1; end
      3'b101:  acc_two_pass_s = 1'b1;
      default: acc_two_pass_s = 1'b0;
    endcase
  end

  // Digit datapath: operand B select, shared digit adder/subtractor and compare terms.
  always_comb begin
    last_s   = (idx_r == IDX_W'(NDIG - 1));
    if (use_imm_r) begin
      b_s = DIGIT_W'(imm >> (int'(idx_r) * DIGIT_W));
    end else begin
      b_s = rs2_digit;
    end
    inv_s    = (f3_r == 3'b000) ? alt_r : 1'b1;
    b_eff_s  = inv_s ? ~b_s : b_s;
    sum_s    = {1'b0, rs1_digit} + {1'b0, b_eff_s} + {{DIGIT_W{1'b0}}, carry_r};
    eq_nxt_s = eq_r & (rs1_digit == b_s);
    // Signs differ: A<B iff A negative; otherwise the difference sign decides.
    lt_s     = (rs1_digit[DIGIT_W-1] ^ b_s[DIGIT_W-1]) ? rs1_digit[DIGIT_W-1] : sum_s[DIGIT_W-1];
    ltu_s    = ~sum_s[DIGIT_W];
  end

  // Shifter: amount collected from the low rs2 digits or taken from imm, result sliced per digit.
  always_comb begin
    shamt_cap_s = shamt_r | 5'({{(XLEN-DIGIT_W){1'b0}}, rs2_digit} << (int'(idx_r) * DIGIT_W));
    shamt_use_s = use_imm_r ? imm[4:0] : shamt_r;
    case (f3_r)
      3'b001:  shifted_s = buf_r << shamt_use_s;
      3'b101:  shifted_s = alt_r ? XLEN'($signed(buf_r) >>> shamt_use_s) : (buf_r >> shamt_use_s);
      default: shifted_s = buf_r;
    endcase
    shift_dig_s = DIGIT_W'(shifted_s >> (int'(idx_r) * DIGIT_W));
  end

  // Result digit for the current index; forced to zero whenever no write is issued.
  always_comb begin
    rd_digit = {DIGIT_W{1'b0}};
    if (rd_wr_r) begin
      case (f3_r)
        3'b000:  rd_digit = sum_s[DIGIT_W-1:0];
        3'b001:  rd_digit = shift_dig_s;
        3'b010:  rd_digit = (idx_r == {IDX_W{1'b0}}) ? DIGIT_W'(flags_r[1]) : {DIGIT_W{1'b0}};
        3'b011:  rd_digit = (idx_r == {IDX_W{1'b0}}) ? DIGIT_W'(flags_r[0]) : {DIGIT_W{1'b0}};
        3'b100:  rd_digit = rs1_digit ^ b_s;
        3'b101:  rd_digit = shift_dig_s;
        3'b110:  rd_digit = rs1_digit | b_s;
        3'b111:  rd_digit = rs1_digit & b_s;
        default: rd_digit = {DIGIT_W{1'b0}};
      endcase
    end else begin
      rd_digit = {DIGIT_W{1'b0}};
    end
  end

  // Sequencer: IDLE -> (CAPTURE) -> EMIT -> IDLE with registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      f3_r      <= 3'b000;
      alt_r     <= 1'b0;
      use_imm_r <= 1'b0;
      carry_r   <= 1'b0;
      eq_r      <= 1'b0;
      buf_r     <= {XLEN{1'b0}};
      shamt_r   <= 5'd0;
      idx_r     <= {IDX_W{1'b0}};
      rd_wr_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      flags_r   <= 3'b000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            f3_r      <= acc_f3_s;
            alt_r     <= (acc_f3_s == 3'b000) ? acc_sub_s : op[3];
            use_imm_r <= use_imm;
            carry_r   <= acc_sub_s;
            eq_r      <= 1'b1;
            shamt_r   <= 5'd0;
            flags_r   <= 3'b000;
            idx_r     <= {IDX_W{1'b0}};
            busy_r    <= 1'b1;
            rd_wr_r   <= ~acc_two_pass_s;
            state_r   <= acc_two_pass_s ? ST_CAPTURE : ST_EMIT;
          end
        end
        ST_CAPTURE: begin
          buf_r   <= {rs1_digit, buf_r[XLEN-1:DIGIT_W]};
          shamt_r <= shamt_cap_s;
          carry_r <= sum_s[DIGIT_W];
          eq_r    <= eq_nxt_s;
          if (last_s) begin
            if ((f3_r == 3'b010) || (f3_r == 3'b011)) begin
              flags_r <= {eq_nxt_s, lt_s, ltu_s};
            end
            idx_r   <= {IDX_W{1'b0}};
            rd_wr_r <= 1'b1;
            state_r <= ST_EMIT;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_EMIT: begin
          carry_r <= sum_s[DIGIT_W];
          eq_r    <= eq_nxt_s;
          if (last_s) begin
            if ((f3_r == 3'b000) && alt_r) begin
              flags_r <= {eq_nxt_s, lt_s, ltu_s};
            end
            idx_r   <= {IDX_W{1'b0}};
            rd_wr_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= {IDX_W{1'b0}};
          rd_wr_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign digit_idx = idx_r;
  assign rd_wr     = rd_wr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign flags     = flags_r;

endmodule
